// File: rtl/demux_8_reg_pkg.sv
// Shared constants and the address decode for the registered 1-to-8 distributor.
package demux_8_reg_pkg;

  localparam int NCH       = 8;
  localparam int ADDR_W    = 3;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // One-hot channel select: addr 0 -> bit 0 (out1) ... addr 7 -> bit 7 (out8).
  function automatic logic [NCH-1:0] addr_decode(input logic [ADDR_W-1:0] addr);
    logic [NCH-1:0] one;
    one = {{(NCH-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

endpackage

// File: rtl/demux_8_reg_if.sv
// Producer/consumer bus of the distributor: one input word stream, eight output slots.
interface demux_8_reg_if
  import demux_8_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic              nCS;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  din;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out1;
  logic [WIDTH-1:0]  out2;
  logic [WIDTH-1:0]  out3;
  logic [WIDTH-1:0]  out4;
  logic [WIDTH-1:0]  out5;
  logic [WIDTH-1:0]  out6;
  logic [WIDTH-1:0]  out7;
  logic [WIDTH-1:0]  out8;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [CNT_W-1:0]  xfer_cnt;

  // Environment side: producer plus the eight consumers.
  modport master (
    output nCS, addr, din, in_valid, out_ready,
    input  in_ready, out1, out2, out3, out4, out5, out6, out7, out8,
           out_valid, xfer_cnt
  );

  // Distributor side.
  modport slave (
    input  nCS, addr, din, in_valid, out_ready,
    output in_ready, out1, out2, out3, out4, out5, out6, out7, out8,
           out_valid, xfer_cnt
  );

endinterface

// File: rtl/demux_8_reg_slot.sv
// One-entry holding slot: a valid flag plus a data register, loaded by the
// distributor and drained by its consumer.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load wins over drain so a simultaneous take-and-refill keeps the slot full;
  // a plain drain only clears the flag and leaves the last word in place.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && drain) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  // A slot can take a new word if empty or being emptied this cycle.
  assign free  = !valid_q || drain;

endmodule

// File: rtl/demux_8_reg.sv
// Registered 1-to-8 distributor: steers each accepted input word into the
// holding slot of the addressed channel and counts accepted words.
module demux_8_reg
  import demux_8_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_8_reg_if.slave  bus
);

  logic [NCH-1:0]   slot_free;
  logic [NCH-1:0]   slot_valid;
  logic [NCH-1:0]   slot_load;
  logic [WIDTH-1:0] slot_data [NCH];
  logic             in_ready;
  logic             accept;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  // Acceptance is combinational on the addressed slot, so a consumer draining
  // this cycle lets the producer refill the same slot without a bubble.
  always_comb begin
    in_ready  = !bus.nCS && slot_free[bus.addr];
    accept    = bus.in_valid && in_ready;
    slot_load = accept ? addr_decode(bus.addr) : '0;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (slot_load[k]),
      .din   (bus.din),
      .drain (bus.out_ready[k]),
      .data  (slot_data[k]),
      .valid (slot_valid[k]),
      .free  (slot_free[k])
    );
  end

  // Accepted-word counter, wrapping silently.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (accept) xfer_cnt_d = xfer_cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = slot_valid;
  assign bus.xfer_cnt  = xfer_cnt_q;
  assign bus.out1      = slot_data[0];
  assign bus.out2      = slot_data[1];
  assign bus.out3      = slot_data[2];
  assign bus.out4      = slot_data[3];
  assign bus.out5      = slot_data[4];
  assign bus.out6      = slot_data[5];
  assign bus.out7      = slot_data[6];
  assign bus.out8      = slot_data[7];

endmodule

// File: tb/tb_demux_8_reg.sv
// Directed bench for the registered 1-to-8 distributor.
module tb_demux_8_reg;
  import demux_8_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  demux_8_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux_8_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] out_ch(input int k);
    case (k)
      0: return bus.out1;
      1: return bus.out2;
      2: return bus.out3;
      3: return bus.out4;
      4: return bus.out5;
      5: return bus.out6;
      6: return bus.out7;
      default: return bus.out8;
    endcase
  endfunction

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.nCS       = 1'b1;
    bus.addr      = '0;
    bus.din       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'h00);
    check("rst_cnt",   32'(bus.xfer_cnt),  32'h0);
    check("rst_out1",  32'(bus.out1),      32'h00);
    rst_n = 1'b1;
    tick();

    // Fill all eight slots with consumers stalled.
    bus.nCS = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.addr     = 3'(i);
      bus.din      = 8'((i + 1) * 8'h11);
      bus.in_valid = 1'b1;
      #1;
      check($sformatf("fill_rdy%0d", i), 32'(bus.in_ready), 32'h1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("fill_valid", 32'(bus.out_valid), 32'hFF);
    for (int i = 0; i < 8; i++)
      check($sformatf("fill_out%0d", i + 1), 32'(out_ch(i)), 32'((i + 1) * 8'h11));
    check("fill_cnt", 32'(bus.xfer_cnt), 32'h8);

    // Ninth word to a full slot is refused.
    bus.addr = 3'd3; bus.din = 8'hEE; bus.in_valid = 1'b1;
    #1;
    check("full_rdy", 32'(bus.in_ready), 32'h0);
    tick();
    check("full_out4", 32'(bus.out4), 32'h44);
    check("full_cnt",  32'(bus.xfer_cnt), 32'h8);
    bus.in_valid = 1'b0;

    // Asynchronous reset mid-cycle with all slots full.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'h00);
    check("arst_out1",  32'(bus.out1),      32'h00);
    check("arst_out8",  32'(bus.out8),      32'h00);
    check("arst_cnt",   32'(bus.xfer_cnt),  32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Streaming through channel 2 with the consumer always ready.
    bus.addr = 3'd2; bus.out_ready = 8'h04; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.din = 8'(8'hA0 + i);
      #1;
      check($sformatf("strm_rdy%0d", i), 32'(bus.in_ready), 32'h1);
      tick();
      check($sformatf("strm_out3_%0d", i), 32'(bus.out3), 32'(8'hA0 + i));
      check($sformatf("strm_vld%0d", i), 32'(bus.out_valid[2]), 32'h1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("strm_drained", 32'(bus.out_valid), 32'h00);
    check("strm_hold",    32'(bus.out3),      32'hA2);
    check("strm_cnt",     32'(bus.xfer_cnt),  32'h3);
    bus.out_ready = '0;

    // Chip select blocks input but not draining.
    bus.addr = 3'd5; bus.din = 8'h5A; bus.in_valid = 1'b1;
    tick();
    bus.nCS = 1'b1; bus.din = 8'hEE;
    #1;
    check("cs_rdy_full", 32'(bus.in_ready), 32'h0);
    bus.addr = 3'd0;
    #1;
    check("cs_rdy_empty", 32'(bus.in_ready), 32'h0);
    tick();
    check("cs_out6",  32'(bus.out6),      32'h5A);
    check("cs_valid", 32'(bus.out_valid), 32'h20);
    check("cs_cnt",   32'(bus.xfer_cnt),  32'h4);
    bus.out_ready = 8'h20;
    tick();
    check("cs_drain", 32'(bus.out_valid), 32'h00);
    check("cs_keep",  32'(bus.out6),      32'h5A);
    bus.in_valid = 1'b0; bus.nCS = 1'b0; bus.out_ready = '0;

    // Independence: fill channels 0 and 7, drain only 7.
    bus.in_valid = 1'b1;
    bus.addr = 3'd0; bus.din = 8'h01;
    tick();
    bus.addr = 3'd7; bus.din = 8'h80;
    tick();
    bus.in_valid = 1'b0;
    check("ind_valid", 32'(bus.out_valid), 32'h81);
    bus.out_ready = 8'h80; bus.addr = 3'd7;
    #1;
    check("ind_passthru", 32'(bus.in_ready), 32'h1);
    tick();
    check("ind_after", 32'(bus.out_valid), 32'h01);
    check("ind_out1",  32'(bus.out1),      32'h01);
    check("ind_cnt",   32'(bus.xfer_cnt),  32'h6);
    bus.out_ready = '0;

    // Counter wrap: 17 accepts on a 4-bit counter.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.addr = 3'd0; bus.out_ready = 8'h01; bus.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.din = 8'(i);
      tick();
      if (i == 15) check("wrap_16", 32'(bus.xfer_cnt), 32'h0);
    end
    bus.in_valid = 1'b0;
    check("wrap_17", 32'(bus.xfer_cnt), 32'h1);
    check("wrap_out1", 32'(bus.out1), 32'h10);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
